// File: rtl/seq_pattern_generator.sv
// Serialises a PAT_W-bit pattern MSB-first, repeating it rep_cnt times with gap_cnt idle cycles between repeats.
// Define SEQ_GEN_OVERLAP_EN so that repeats after the first send only the low PAT_W-OVL bits.
module seq_pattern_generator #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int OVL   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic [CNT_W-1:0] gap_cnt,
    output logic             x_out,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = $clog2(PAT_W);
`ifdef SEQ_GEN_OVERLAP_EN
    localparam int REP_TOP = PAT_W - 1 - OVL;
`else
    localparam int REP_TOP = PAT_W - 1;
`endif
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] NEXT_IDX  = IDX_W'(REP_TOP);

    if (PAT_W < 2 || OVL < 0 || OVL >= PAT_W) begin : g_bad_params
        $error("seq_pattern_generator: need PAT_W >= 2 and 0 <= OVL < PAT_W");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             x_out_q, x_out_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] rem_m1;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        rem_d     = rem_q;
        gap_d     = gap_q;
        gcnt_d    = gcnt_q;
        idx_d     = idx_q;
        x_out_d   = 1'b0;
        x_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        rem_m1    = rem_q - 1'b1;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pat_d = pat_in;
                    rem_d = rep_cnt;
                    gap_d = gap_cnt;
                    if (rep_cnt != '0) begin
                        state_d   = SHIFT;
                        idx_d     = FIRST_IDX;
                        x_out_d   = pat_in[PAT_W-1];
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    gcnt_d  = '0;
                end else if (idx_q != '0) begin
                    idx_d     = idx_q - 1'b1;
                    x_out_d   = pat_q[idx_q-1'b1];
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    // Last bit of a repeat is on the line now: decide what follows it.
                    rem_d = rem_m1;
                    if (rem_m1 == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (gap_q != '0) begin
                        state_d = GAP;
                        gcnt_d  = gap_q - 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        idx_d     = NEXT_IDX;
                        x_out_d   = pat_q[NEXT_IDX];
                        x_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = '0;
                    gcnt_d  = '0;
                end else if (gcnt_q == '0) begin
                    state_d   = SHIFT;
                    idx_d     = NEXT_IDX;
                    x_out_d   = pat_q[NEXT_IDX];
                    x_valid_d = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            gcnt_q    <= '0;
            idx_q     <= '0;
            x_out_q   <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            gcnt_q    <= gcnt_d;
            idx_q     <= idx_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign x_out   = x_out_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
